// File: rtl/udma_i2c_cmd_arb_if.sv
// Controller-side stream bundle of the I2C command arbiter: command bytes out, read bytes back.
// Member names match the arbiter's external port names so both ends read the same.
interface udma_i2c_cmd_arb_if;
    logic [7:0] cmd_data_o;
    logic       cmd_valid_o;
    logic       cmd_ready_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;

    modport master (
        output cmd_data_o, cmd_valid_o, rx_ready_o,
        input  cmd_ready_i, rx_data_i, rx_valid_i
    );

    modport slave (
        input  cmd_data_o, cmd_valid_o, rx_ready_o,
        output cmd_ready_i, rx_data_i, rx_valid_i
    );
endinterface

// File: rtl/udma_i2c_cmd_arb.sv
// Round-robin arbiter for the uDMA I2C command stream: holds a grant for a whole
// START..STOP transaction or one stand-alone command, and routes read bytes back to the owner.
module udma_i2c_cmd_arb #(
    parameter int NB_REQ     = 2,
    parameter int PEND_WIDTH = 9
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        sw_rst_i,
    input  logic [NB_REQ*8-1:0]         req_data_i,
    input  logic [NB_REQ-1:0]           req_valid_i,
    output logic [NB_REQ-1:0]           req_ready_o,
    udma_i2c_cmd_arb_if.master          ctl,
    output logic [NB_REQ*8-1:0]         rx_data_o,
    output logic [NB_REQ-1:0]           rx_valid_o,
    input  logic [NB_REQ-1:0]           rx_ready_i,
    output logic [$clog2(NB_REQ)-1:0]   owner_o,
    output logic                        busy_o,
    output logic                        err_o
);
    localparam int OW = $clog2(NB_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CMD   = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [3:0] C_START = 4'h0;
    localparam logic [3:0] C_STOP  = 4'h2;
    localparam logic [3:0] C_RDACK = 4'h4;
    localparam logic [3:0] C_RDNAK = 4'h6;
    localparam logic [3:0] C_RPT   = 4'hC;

    function automatic logic [1:0] pay_len(input logic [3:0] code);
        case (code)
            4'h8, 4'hA, 4'hC: pay_len = 2'd1;
            4'hE:             pay_len = 2'd2;
            default:          pay_len = 2'd0;
        endcase
    endfunction

    logic [1:0]            r_state;
    logic [OW-1:0]         r_owner;
    logic [OW-1:0]         r_last_owner;
    logic                  r_in_txn;
    logic [1:0]            r_pay_cnt;
    logic [7:0]            r_rpt_cnt;
    logic                  r_rpt_arm;
    logic                  r_cur_rpt;
    logic [PEND_WIDTH-1:0] r_pend_rd;
    logic                  r_err;

    logic [7:0]            w_req_bytes [NB_REQ];
    logic [7:0]            w_sel_data;
    logic                  w_sel_valid;
    logic [3:0]            w_code;
    logic                  w_fwd;
    logic                  w_is_rd;
    logic [PEND_WIDTH-1:0] w_rd_inc;
    logic [PEND_WIDTH:0]   w_sum;
    logic                  w_stall;
    logic                  w_hs;
    logic                  w_pend_nz;
    logic                  w_rx_hs;
    logic [PEND_WIDTH-1:0] w_inc;
    logic                  w_in_txn_nxt;
    logic                  w_any;
    logic [OW-1:0]         w_winner;
    logic [OW-1:0]         w_idx;

    for (genvar g = 0; g < NB_REQ; g++) begin : g_unpack
        assign w_req_bytes[g] = req_data_i[g*8 +: 8];
    end

    assign w_sel_data  = w_req_bytes[r_owner];
    assign w_sel_valid = req_valid_i[r_owner];
    assign w_code      = w_sel_data[7:4];
    assign w_fwd       = (r_state == S_CMD) || (r_state == S_DATA);
    assign w_is_rd     = (r_state == S_CMD) && ((w_code == C_RDACK) || (w_code == C_RDNAK));
    assign w_rd_inc    = r_rpt_arm ? PEND_WIDTH'(r_rpt_cnt) : PEND_WIDTH'(1);
    assign w_sum       = {1'b0, r_pend_rd} + {1'b0, w_rd_inc};
    // A read that would wrap the outstanding counter is held off until bytes drain.
    assign w_stall     = w_is_rd && w_sum[PEND_WIDTH];
    assign w_hs        = w_fwd && w_sel_valid && !w_stall && ctl.cmd_ready_i;
    assign w_inc       = (w_hs && w_is_rd) ? w_rd_inc : '0;
    assign w_in_txn_nxt = (w_code == C_START) ? 1'b1 :
                          (w_code == C_STOP)  ? 1'b0 : r_in_txn;

    assign w_pend_nz = (r_pend_rd != '0);
    assign w_rx_hs   = w_pend_nz && ctl.rx_valid_i && rx_ready_i[r_owner];

    assign ctl.cmd_data_o  = w_fwd ? w_sel_data : 8'h00;
    assign ctl.cmd_valid_o = w_fwd && w_sel_valid && !w_stall;
    assign ctl.rx_ready_o  = w_pend_nz ? rx_ready_i[r_owner] : 1'b1;
    assign rx_data_o       = {NB_REQ{ctl.rx_data_i}};
    assign owner_o         = r_owner;
    assign busy_o          = (r_state != S_IDLE);
    assign err_o           = r_err;

    always_comb begin
        req_ready_o = '0;
        rx_valid_o  = '0;
        req_ready_o[r_owner] = w_fwd && !w_stall && ctl.cmd_ready_i;
        rx_valid_o[r_owner]  = w_pend_nz && ctl.rx_valid_i;
    end

    // Descending scan so the nearest index after last_owner is the one left standing.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_last_owner;
        w_idx    = '0;
        for (int i = NB_REQ; i >= 1; i--) begin
            w_idx = OW'((int'(r_last_owner) + i) % NB_REQ);
            if (req_valid_i[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_owner <= OW'(NB_REQ - 1);
            r_in_txn     <= 1'b0;
            r_pay_cnt    <= 2'd0;
            r_rpt_cnt    <= 8'h00;
            r_rpt_arm    <= 1'b0;
            r_cur_rpt    <= 1'b0;
            r_pend_rd    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= !w_pend_nz && ctl.rx_valid_i;
            if (sw_rst_i) begin
                r_state      <= S_IDLE;
                r_in_txn     <= 1'b0;
                r_rpt_arm    <= 1'b0;
                r_pay_cnt    <= 2'd0;
                r_pend_rd    <= '0;
                r_last_owner <= OW'(NB_REQ - 1);
            end else begin
                r_pend_rd <= r_pend_rd + w_inc - {{(PEND_WIDTH-1){1'b0}}, w_rx_hs};
                case (r_state)
                    S_IDLE: begin
                        if (w_any) begin
                            r_owner <= w_winner;
                            r_state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (w_hs) begin
                            r_in_txn  <= w_in_txn_nxt;
                            r_cur_rpt <= (w_code == C_RPT);
                            if (w_code != C_RPT) r_rpt_arm <= 1'b0;
                            if (pay_len(w_code) != 2'd0) begin
                                r_pay_cnt <= pay_len(w_code);
                                r_state   <= S_DATA;
                            end else if (!w_in_txn_nxt) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_hs) begin
                            r_pay_cnt <= r_pay_cnt - 2'd1;
                            if (r_cur_rpt) begin
                                r_rpt_cnt <= w_sel_data;
                                r_rpt_arm <= 1'b1;
                            end
                            if (r_pay_cnt == 2'd1) r_state <= r_in_txn ? S_CMD : S_DRAIN;
                        end
                    end
                    default: begin
                        if (!w_pend_nz) begin
                            r_last_owner <= r_owner;
                            r_state      <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_udma_i2c_cmd_arb.sv
// Directed bench for udma_i2c_cmd_arb: a cycle table for arbitration/forwarding/err,
// then hand-written sequences for repeated reads, stand-alone CFG and soft reset.
module tb_udma_i2c_cmd_arb;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        sw_rst_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [15:0] rx_data_o;
    logic [1:0]  rx_valid_o;
    logic [1:0]  rx_ready_i;
    logic [0:0]  owner_o;
    logic        busy_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    udma_i2c_cmd_arb_if ctl ();

    udma_i2c_cmd_arb #(.NB_REQ(2), .PEND_WIDTH(9)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .sw_rst_i    (sw_rst_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .ctl         (ctl),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .owner_o     (owner_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] vld;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       crdy;
        logic       rxv;
        logic [7:0] rxd;
        logic [1:0] rxrdy;
        logic       cvld;
        logic [7:0] cdat;
        logic [1:0] rrdy;
        logic       busy;
        logic       own;
        logic       rxro;
        logic [1:0] rxvo;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input int r, input logic [7:0] b);
        bit got;
        logic [1:0] others;
        got = 1'b0;
        req_valid_i[r] = 1'b1;
        req_data_i[r*8 +: 8] = b;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk_i);
            if (req_ready_o[r]) begin
                got = 1'b1;
                others = req_ready_o;
                others[r] = 1'b0;
                chk($sformatf("fwd_data r%0d b%02h", r, b), 32'(ctl.cmd_data_o), 32'(b));
                chk($sformatf("fwd_valid r%0d b%02h", r, b), 32'(ctl.cmd_valid_o), 32'd1);
                chk($sformatf("fwd_owner r%0d b%02h", r, b), 32'(owner_o), 32'(r));
                chk($sformatf("no_interleave r%0d b%02h", r, b), 32'(others), 32'd0);
            end
            @(posedge clk_i);
            #1;
        end
        req_valid_i[r] = 1'b0;
        if (!got) chk($sformatf("send_timeout r%0d b%02h", r, b), 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 20 && !idle; k++) begin
            @(negedge clk_i);
            if (!busy_o) idle = 1'b1;
            @(posedge clk_i);
            #1;
        end
        chk(nm, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i          = 1'b0;
        sw_rst_i        = 1'b0;
        req_data_i      = '0;
        req_valid_i     = '0;
        rx_ready_i      = '0;
        ctl.cmd_ready_i = 1'b1;
        ctl.rx_data_i   = 8'h00;
        ctl.rx_valid_i  = 1'b0;

        //           vld    d0     d1     crdy  rxv   rxd    rxrdy  cvld  cdat   rrdy   busy  own   rxro  rxvo   err
        tbl.push_back('{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 8'h80, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h80, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h80, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'hA5, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h20, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h20, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b10, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b10, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b10, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h00, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h00, 8'h20, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h20, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b01, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h00, 8'h20, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h00, 8'h20, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b11, 8'h20, 8'h20, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h20, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b10, 8'h00, 8'h20, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b10, 8'h00, 8'h20, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b10, 8'h00, 8'h20, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h20, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0});
        tbl.push_back('{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1});
        tbl.push_back('{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0});

        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;

        foreach (tbl[i]) begin
            req_valid_i     = tbl[i].vld;
            req_data_i      = {tbl[i].d1, tbl[i].d0};
            ctl.cmd_ready_i = tbl[i].crdy;
            ctl.rx_valid_i  = tbl[i].rxv;
            ctl.rx_data_i   = tbl[i].rxd;
            rx_ready_i      = tbl[i].rxrdy;
            @(negedge clk_i);
            chk($sformatf("row%0d cmd_valid", i), 32'(ctl.cmd_valid_o), 32'(tbl[i].cvld));
            chk($sformatf("row%0d cmd_data", i),  32'(ctl.cmd_data_o),  32'(tbl[i].cdat));
            chk($sformatf("row%0d req_ready", i), 32'(req_ready_o),     32'(tbl[i].rrdy));
            chk($sformatf("row%0d busy", i),      32'(busy_o),          32'(tbl[i].busy));
            chk($sformatf("row%0d owner", i),     32'(owner_o),         32'(tbl[i].own));
            chk($sformatf("row%0d rx_ready", i),  32'(ctl.rx_ready_o),  32'(tbl[i].rxro));
            chk($sformatf("row%0d rx_valid", i),  32'(rx_valid_o),      32'(tbl[i].rxvo));
            chk($sformatf("row%0d err", i),       32'(err_o),           32'(tbl[i].err));
            @(posedge clk_i);
            #1;
        end
        req_valid_i     = '0;
        req_data_i      = '0;
        ctl.cmd_ready_i = 1'b1;
        ctl.rx_valid_i  = 1'b0;

        // Repeated read: RPT 4, RD_ACK, RD_NACK -> five reads owed to req1.
        send(1, 8'h00);
        req_valid_i[0] = 1'b1;
        req_data_i[7:0] = 8'h00;
        send(1, 8'hC0);
        send(1, 8'h04);
        send(1, 8'h40);
        chk("pend_after_rdack", 32'(dut.r_pend_rd), 32'd4);
        send(1, 8'h60);
        chk("pend_after_rdnack", 32'(dut.r_pend_rd), 32'd5);
        req_valid_i[0] = 1'b1;
        req_data_i[7:0] = 8'h00;
        send(1, 8'h20);
        req_valid_i[0] = 1'b1;
        ctl.rx_valid_i = 1'b1;
        ctl.rx_data_i  = 8'h3C;
        rx_ready_i     = 2'b00;
        @(negedge clk_i);
        chk("rx_backpressure_ready", 32'(ctl.rx_ready_o), 32'd0);
        chk("rx_backpressure_valid", 32'(rx_valid_o), 32'd2);
        @(posedge clk_i);
        #1;
        rx_ready_i = 2'b10;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] bv;
            bv = 8'h30 + 8'(i);
            ctl.rx_data_i = bv;
            @(negedge clk_i);
            chk($sformatf("rx%0d valid_o", i), 32'(rx_valid_o), 32'd2);
            chk($sformatf("rx%0d data_o", i), 32'(rx_data_o[15:8]), 32'(bv));
            chk($sformatf("rx%0d ready_o", i), 32'(ctl.rx_ready_o), 32'd1);
            chk($sformatf("rx%0d req0_blocked", i), 32'(req_ready_o[0]), 32'd0);
            chk($sformatf("rx%0d busy", i), 32'(busy_o), 32'd1);
            chk($sformatf("rx%0d pend", i), 32'(dut.r_pend_rd), 32'(5 - i));
            @(posedge clk_i);
            #1;
        end
        ctl.rx_valid_i = 1'b0;
        rx_ready_i     = 2'b00;
        chk("pend_drained", 32'(dut.r_pend_rd), 32'd0);
        @(negedge clk_i);
        chk("drain_last_cycle_busy", 32'(busy_o), 32'd1);
        chk("drain_last_cycle_owner", 32'(owner_o), 32'd1);
        @(posedge clk_i);
        #1;
        send(0, 8'h00);
        send(0, 8'h20);
        wait_idle("idle_after_req0_txn");

        // Stand-alone CFG from req0 with req1 waiting.
        send(0, 8'hE0);
        req_valid_i[1] = 1'b1;
        req_data_i[15:8] = 8'h20;
        send(0, 8'h01);
        req_valid_i[1] = 1'b1;
        send(0, 8'h90);
        req_valid_i[1] = 1'b1;
        @(negedge clk_i);
        chk("cfg_drain_busy", 32'(busy_o), 32'd1);
        chk("cfg_drain_owner", 32'(owner_o), 32'd0);
        chk("cfg_drain_req_ready", 32'(req_ready_o), 32'd0);
        chk("cfg_drain_cmd_valid", 32'(ctl.cmd_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("cfg_idle_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1;
        send(1, 8'h20);
        wait_idle("idle_after_req1_stop");

        // Soft reset in the middle of a transaction.
        send(0, 8'h00);
        send(0, 8'h40);
        send(0, 8'h80);
        chk("sw_pre_pend", 32'(dut.r_pend_rd), 32'd1);
        ctl.cmd_ready_i = 1'b0;
        req_valid_i[0] = 1'b1;
        req_data_i[7:0] = 8'h55;
        @(negedge clk_i);
        chk("sw_pre_cmd_valid", 32'(ctl.cmd_valid_o), 32'd1);
        chk("sw_pre_busy", 32'(busy_o), 32'd1);
        @(posedge clk_i);
        #1;
        sw_rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        sw_rst_i = 1'b0;
        req_valid_i[0] = 1'b0;
        @(negedge clk_i);
        chk("sw_busy", 32'(busy_o), 32'd0);
        chk("sw_pend", 32'(dut.r_pend_rd), 32'd0);
        chk("sw_cmd_valid", 32'(ctl.cmd_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        ctl.cmd_ready_i = 1'b1;
        send(1, 8'h20);
        wait_idle("idle_after_sw_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/udma_i2c_cmd_arb.md
# udma_i2c_cmd_arb

Arbitrates the I2C command/data byte stream of the uDMA I2C peripheral between NB_REQ independent TX requesters, and feeds a single stream into the I2C command controller. A grant is held atomically for a whole I2C transaction, from START through STOP, or for a single stand-alone command with its payload. Read bytes returned by the controller are routed back to the requester that issued the reads. The block sits in the periph clock domain, between the TX clock-domain-crossing FIFOs and the I2C controller.

## Interface
- NB_REQ, 2: number of requesters (≥2)
- PEND_WIDTH, 9: width of the outstanding-read counter
- clk_i  in  1  periph clock
- rstn_i  in  1  asynchronous active-low reset
- sw_rst_i  in  1  synchronous soft reset (one-cycle pulse)
- req_data_i  in  NB_REQ×8  per-requester command/data byte
- req_valid_i  in  NB_REQ  per-requester byte valid
- req_ready_o  out  NB_REQ  per-requester byte accepted
- cmd_data_o  out  8  byte to the I2C controller
- cmd_valid_o  out  1  byte valid
- cmd_ready_i  in  1  controller accepts byte
- rx_data_i  in  8  read byte from the controller
- rx_valid_i  in  1  read byte valid
- rx_ready_o  out  1  read byte accepted
- rx_data_o  out  NB_REQ×8  per-requester read byte (rx_data_i fanned out)
- rx_valid_o  out  NB_REQ  per-requester read valid
- rx_ready_i  in  NB_REQ  per-requester read ready
- owner_o  out  $clog2(NB_REQ)  current grant holder
- busy_o  out  1  state ≠ IDLE
- err_o  out  1  one-cycle pulse: read byte received with no outstanding read

## Operation
- Command code is byte[7:4]:
  - START=0x0, WAIT_EV=0x1, STOP=0x2, RD_ACK=0x4, RD_NACK=0x6 carry 0 payload bytes.
  - WR=0x8, WAIT=0xA, RPT=0xC carry 1 payload byte. CFG=0xE carries 2.
  - Undefined codes carry 0 payload bytes.
- Registers:
  - state ∈ {IDLE, CMD, DATA, DRAIN}
  - owner, last_owner
  - in_txn
  - pay_cnt (2 bit)
  - rpt_cnt (8 bit)
  - rpt_arm
  - pend_rd (PEND_WIDTH)
- IDLE:
  - Nothing is forwarded.
  - If any req_valid_i is set, owner ← first valid index, searching round-robin from last_owner+1. State → CMD.
- CMD forwarding: cmd_data_o=req_data_i[owner], cmd_valid_o=req_valid_i[owner], req_ready_o[owner]=cmd_ready_i. All other req_ready_o bits are 0.
- CMD, on handshake:
  - START sets in_txn; STOP clears it.
  - RD_ACK/RD_NACK: pend_rd += (rpt_arm ? rpt_cnt : 1).
  - Any command other than RPT clears rpt_arm.
  - Payload > 0: pay_cnt ← count, state → DATA.
  - Payload = 0: stay in CMD if in_txn (post-update) is set, else → DRAIN.
- DATA, on each handshake:
  - pay_cnt decrements.
  - If the current command is RPT, rpt_cnt ← byte and rpt_arm ← 1.
  - On the last payload byte: → CMD if in_txn, else → DRAIN.
  - A stand-alone command plus its payload therefore forms one atomic grant.
- Read-counter saturation: if a RD handshake would overflow pend_rd, cmd_valid_o and req_ready_o[owner] are forced to 0 (stall) until there is room. RPT count 0 adds 0.
- DRAIN: waits for pend_rd==0, then last_owner ← owner, state → IDLE.
- RX routing:
  - While pend_rd>0: rx_valid_o[owner]=rx_valid_i and rx_ready_o=rx_ready_i[owner]. pend_rd decrements on each handshake.
  - When the increment and the decrement occur in the same cycle, pend_rd = pend_rd + inc − 1.
  - While pend_rd==0: rx_ready_o=1, all rx_valid_o=0. A byte with rx_valid_i in this condition is dropped and err_o pulses.
- sw_rst_i: on the next edge, state → IDLE, in_txn/rpt_arm/pay_cnt/pend_rd → 0, last_owner → NB_REQ−1. This abandons any transaction in progress, and the handshake in that cycle is not counted.

## Timing
- Reset values:
  - req_ready_o=0, cmd_valid_o=0, cmd_data_o=0 (driven as 0 while IDLE)
  - rx_ready_o=1, rx_valid_o=0, owner_o=0, busy_o=0, err_o=0
  - last_owner=NB_REQ−1, so requester 0 wins first
- Arbitration latency: 1 cycle. A requester valid in cycle n is forwarded starting in cycle n+1.
- Forwarding: combinational pass-through, zero added latency, one byte per cycle at full throughput.
- Grant release: DRAIN→IDLE takes 1 cycle after pend_rd reaches 0. The next grant starts 1 cycle later.
- valid/ready rules: req_valid_i must stay high until ready. The block never drops cmd_valid_o without a handshake, except on sw_rst_i.
- err_o is registered and pulses for 1 cycle after the offending byte.

## Test plan
- Req0 sends 0x00, 0x80, 0xA5, 0x20 (START, WR A5, STOP) with no reads.
  - Required: all 4 bytes forwarded in order; busy_o drops 2 cycles after the STOP handshake.
  - Req1, valid throughout, gets its first handshake only after that.
- Req0 and req1 both valid from reset, each with a START…STOP sequence.
  - Required: owner_o=0 first, then 1, then 0 again on the next contention (round-robin).
- Req1 sends 0x00, 0xC0, 0x04, 0x40, 0x60, 0x20 (RPT 4 ×RD_ACK, RD_NACK, STOP).
  - Required: pend_rd=5 after the RD_NACK handshake.
  - Grant held until 5 rx bytes are delivered to rx_valid_o[1]; req0 is blocked until then.
- Stand-alone CFG from req0: 0xE0, 0x01, 0x90.
  - Required: 3 bytes forwarded atomically; req1 cannot interleave; state → DRAIN → IDLE.
- rx_valid_i asserted with pend_rd=0.
  - Required: byte accepted (rx_ready_o=1), no rx_valid_o, err_o=1 for exactly 1 cycle.
- sw_rst_i pulse mid-transaction (after START, WR) with cmd_ready_i held low.
  - Required: next cycle busy_o=0, pend_rd=0; a fresh request from req1 is granted.
